// File: rtl/spell_shift_port.sv
// spell_shift_port: serial host port that dumps a core register out over a
// strobe-clocked shift register, or loads a byte from the host and writes it
// into a core register while the CPU is halted. Every host pin is
// asynchronous and passes through a synchroniser. Strobe rises are detected
// as edges, so a strobe that is held high counts only once.
module spell_shift_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_dump,
  input  logic       i_shift_in,
  input  logic [1:0] i_reg_sel,
  input  logic       cpu_halted,
  input  logic [7:0] reg_rdata,
  output logic [1:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       o_shift_out,
  output logic       o_busy,
  output logic       o_err
);

  // Anything shorter than two stages is not a real synchroniser, so the
  // depth is clamped at two.
  localparam int STG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // The frame direction is fixed by the first strobe of a frame.
  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_DUMP = 1'b1
  } mode_e;

  // ---------------------------------------------------------------------
  // Input synchronisers, one chain per asynchronous pin
  // ---------------------------------------------------------------------
  logic [STG-1:0] load_sync_r;
  logic [STG-1:0] dump_sync_r;
  logic [STG-1:0] sin_sync_r;
  logic [STG-1:0] sel0_sync_r;
  logic [STG-1:0] sel1_sync_r;

  // Shift every asynchronous host pin through its own synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync_r <= '0;
      dump_sync_r <= '0;
      sin_sync_r  <= '0;
      sel0_sync_r <= '0;
      sel1_sync_r <= '0;
    end else begin
      load_sync_r <= {load_sync_r[STG-2:0], i_load};
      dump_sync_r <= {dump_sync_r[STG-2:0], i_dump};
      sin_sync_r  <= {sin_sync_r[STG-2:0], i_shift_in};
      sel0_sync_r <= {sel0_sync_r[STG-2:0], i_reg_sel[0]};
      sel1_sync_r <= {sel1_sync_r[STG-2:0], i_reg_sel[1]};
    end
  end

  logic       load_s;
  logic       dump_s;
  logic       sin_s;
  logic [1:0] sel_s;

  assign load_s = load_sync_r[STG-1];
  assign dump_s = dump_sync_r[STG-1];
  assign sin_s  = sin_sync_r[STG-1];
  assign sel_s  = {sel1_sync_r[STG-1], sel0_sync_r[STG-1]};

  // ---------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------
  logic load_prev_r;
  logic dump_prev_r;

  // Remember the previous synchronised strobe level for rise detection.
  // The flops clear on reset, so a strobe that is already high when reset
  // is released is seen as a fresh rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_prev_r <= 1'b0;
      dump_prev_r <= 1'b0;
    end else begin
      load_prev_r <= load_s;
      dump_prev_r <= dump_s;
    end
  end

  logic load_rise_s;
  logic dump_rise_s;

  assign load_rise_s = load_s & ~load_prev_r;
  assign dump_rise_s = dump_s & ~dump_prev_r;

  // ---------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------
  logic [7:0] shreg_r;
  logic [2:0] cnt_r;
  mode_e      mode_r;
  logic [1:0] sel_q_r;
  logic       we_r;
  logic       err_r;
  logic       busy_r;

  logic [7:0] shreg_nx_s;
  logic [2:0] cnt_nx_s;
  mode_e      mode_nx_s;
  logic [1:0] sel_q_nx_s;
  logic       we_nx_s;
  logic       err_nx_s;

  logic       frame_idle_s;
  logic       same_kind_s;

  assign frame_idle_s = (cnt_r == 3'd0);
  // A rise continues the open frame only when it has the same direction.
  assign same_kind_s  = ((mode_r == MODE_DUMP) == dump_rise_s);

  // Decide the next frame state from the strobe rises seen this cycle.
  always_comb begin
    shreg_nx_s = shreg_r;
    cnt_nx_s   = cnt_r;
    mode_nx_s  = mode_r;
    sel_q_nx_s = sel_q_r;
    we_nx_s    = 1'b0;
    err_nx_s   = err_r;

    if (load_rise_s && dump_rise_s) begin
      // Both strobes at once is ambiguous: flag it and drop any frame.
      err_nx_s = 1'b1;
      cnt_nx_s = 3'd0;
    end else if (load_rise_s || dump_rise_s) begin
      if (frame_idle_s) begin
        // Frame start: capture the target register and the direction.
        sel_q_nx_s = sel_s;
        mode_nx_s  = dump_rise_s ? MODE_DUMP : MODE_LOAD;
        err_nx_s   = 1'b0;
        cnt_nx_s   = 3'd1;
        if (dump_rise_s) begin
          shreg_nx_s = reg_rdata;
        end else begin
          shreg_nx_s = {shreg_r[6:0], sin_s};
        end
      end else if (same_kind_s) begin
        cnt_nx_s = cnt_r + 3'd1;
        if (dump_rise_s) begin
          shreg_nx_s = {shreg_r[6:0], 1'b0};
        end else begin
          shreg_nx_s = {shreg_r[6:0], sin_s};
          if (cnt_r == 3'd7) begin
            // Eighth load bit: commit only while the core is stopped.
            if (cpu_halted) begin
              we_nx_s = 1'b1;
            end else begin
              err_nx_s = 1'b1;
            end
          end else begin
            we_nx_s = 1'b0;
          end
        end
      end else begin
        // A rise of the opposite direction aborts the frame.
        cnt_nx_s = 3'd0;
        err_nx_s = 1'b1;
      end
    end else begin
      we_nx_s = 1'b0;
    end
  end

  // Register the frame state and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= 8'h00;
      cnt_r   <= 3'd0;
      mode_r  <= MODE_LOAD;
      sel_q_r <= 2'd0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      shreg_r <= shreg_nx_s;
      cnt_r   <= cnt_nx_s;
      mode_r  <= mode_nx_s;
      sel_q_r <= sel_q_nx_s;
      we_r    <= we_nx_s;
      err_r   <= err_nx_s;
      busy_r  <= (cnt_nx_s != 3'd0) | we_nx_s;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // While idle, the address follows the live select so that the core read
  // data is already valid at the first dump rise. During a frame, and in
  // the write cycle that ends it (cnt has wrapped to 0 by then), the
  // address holds the latched select.
  assign reg_addr    = (frame_idle_s && !we_r) ? sel_s : sel_q_r;
  assign reg_wdata   = shreg_r;
  assign reg_we      = we_r;
  assign o_shift_out = shreg_r[7];
  assign o_busy      = busy_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_spell_shift_port.sv
// tb_spell_shift_port: directed, table-driven bench for spell_shift_port.
// The bench models the core register file, drives host strobes as pulses,
// and compares the outputs against hand-computed values.
module tb_spell_shift_port;

  logic       clk;
  logic       rst;
  logic       i_load;
  logic       i_dump;
  logic       i_shift_in;
  logic [1:0] i_reg_sel;
  logic       cpu_halted;
  logic [7:0] reg_rdata;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       o_shift_out;
  logic       o_busy;
  logic       o_err;

  logic [7:0] core_mem [4];

  int n_checks;
  int n_fail;
  int we_total;
  logic [7:0] we_wdata;
  logic [1:0] we_addr;

  spell_shift_port #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_load     (i_load),
    .i_dump     (i_dump),
    .i_shift_in (i_shift_in),
    .i_reg_sel  (i_reg_sel),
    .cpu_halted (cpu_halted),
    .reg_rdata  (reg_rdata),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .o_shift_out(o_shift_out),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational core register read model.
  assign reg_rdata = core_mem[reg_addr];

  // Count write cycles and capture what was written.
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      we_total = we_total + 1;
      we_wdata = reg_wdata;
      we_addr  = reg_addr;
    end
  end

  typedef struct {
    bit         is_dump;
    logic [1:0] sel;
    logic [7:0] data;
    bit         halted;
    int         exp_we;
    bit         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe pulse: high for 'hold' cycles, then low for 4 cycles.
  task automatic pulse(input bit dmp, input bit d, input int hold);
    @(negedge clk);
    i_shift_in = d;
    if (dmp) i_dump = 1'b1;
    else     i_load = 1'b1;
    repeat (hold) @(negedge clk);
    i_load = 1'b0;
    i_dump = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;
    logic [7:0] b;
    n_checks   = 0;
    n_fail     = 0;
    we_total   = 0;
    we_wdata   = 8'h00;
    we_addr    = 2'd0;
    rst        = 1'b1;
    i_load     = 1'b0;
    i_dump     = 1'b0;
    i_shift_in = 1'b0;
    i_reg_sel  = 2'd0;
    cpu_halted = 1'b0;
    core_mem[0] = 8'h11;
    core_mem[1] = 8'h22;
    core_mem[2] = 8'h33;
    core_mem[3] = 8'h44;

    vecs[0] = '{is_dump: 1'b1, sel: 2'd1, data: 8'hA5, halted: 1'b0, exp_we: 0, exp_err: 1'b0};
    vecs[1] = '{is_dump: 1'b0, sel: 2'd2, data: 8'hCA, halted: 1'b1, exp_we: 1, exp_err: 1'b0};
    vecs[2] = '{is_dump: 1'b0, sel: 2'd2, data: 8'hCA, halted: 1'b0, exp_we: 0, exp_err: 1'b1};
    vecs[3] = '{is_dump: 1'b1, sel: 2'd3, data: 8'h3C, halted: 1'b0, exp_we: 0, exp_err: 1'b0};
    vecs[4] = '{is_dump: 1'b0, sel: 2'd0, data: 8'h5A, halted: 1'b1, exp_we: 1, exp_err: 1'b0};
    vecs[5] = '{is_dump: 1'b0, sel: 2'd3, data: 8'hFF, halted: 1'b1, exp_we: 1, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_shift_out", o_shift_out, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_we", reg_we, 1'b0);
    check("rst_addr", reg_addr, 2'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven full frames.
    for (int v = 0; v < 6; v++) begin
      i_reg_sel  = vecs[v].sel;
      cpu_halted = vecs[v].halted;
      if (vecs[v].is_dump) core_mem[vecs[v].sel] = vecs[v].data;
      repeat (4) @(negedge clk);
      base = we_total;
      for (int k = 0; k < 8; k++) begin
        b = vecs[v].data;
        pulse(vecs[v].is_dump, b[7-k], 1);
        if (vecs[v].is_dump) check($sformatf("v%0d_bit%0d", v, k), o_shift_out, b[7-k]);
        if (k == 0) check($sformatf("v%0d_busy_mid", v), o_busy, 1'b1);
      end
      check($sformatf("v%0d_busy_end", v), o_busy, 1'b0);
      check($sformatf("v%0d_we_count", v), we_total - base, vecs[v].exp_we);
      check($sformatf("v%0d_err", v), o_err, vecs[v].exp_err);
      if (vecs[v].exp_we == 1) begin
        check($sformatf("v%0d_wdata", v), we_wdata, vecs[v].data);
        check($sformatf("v%0d_waddr", v), we_addr, vecs[v].sel);
      end
      if (!vecs[v].is_dump) check($sformatf("v%0d_shift_out", v), o_shift_out, b[7]);
    end

    // Three loads then a dump aborts; the next eight loads write normally.
    i_reg_sel  = 2'd1;
    cpu_halted = 1'b1;
    repeat (4) @(negedge clk);
    base = we_total;
    pulse(1'b0, 1'b1, 1);
    pulse(1'b0, 1'b0, 1);
    pulse(1'b0, 1'b1, 1);
    pulse(1'b1, 1'b0, 1);
    check("abort_err", o_err, 1'b1);
    check("abort_busy", o_busy, 1'b0);
    check("abort_no_we", we_total - base, 0);
    b = 8'h96;
    for (int k = 0; k < 8; k++) pulse(1'b0, b[7-k], 1);
    check("after_abort_we", we_total - base, 1);
    check("after_abort_wdata", we_wdata, 8'h96);
    check("after_abort_waddr", we_addr, 2'd1);
    check("after_abort_err", o_err, 1'b0);

    // Both strobes together: error, no shift, no write.
    base = we_total;
    @(negedge clk);
    i_load = 1'b1;
    i_dump = 1'b1;
    repeat (4) @(negedge clk);
    i_load = 1'b0;
    i_dump = 1'b0;
    repeat (4) @(negedge clk);
    check("both_err", o_err, 1'b1);
    check("both_busy", o_busy, 1'b0);
    check("both_no_shift", o_shift_out, 1'b1);
    check("both_no_we", we_total - base, 0);

    // A load held for 20 cycles counts as one bit.
    pulse(1'b0, 1'b1, 20);
    check("held_busy", o_busy, 1'b1);
    check("held_err_cleared", o_err, 1'b0);
    check("held_no_we", we_total - base, 0);
    b = 8'h81;
    for (int k = 1; k < 8; k++) pulse(1'b0, b[7-k], 1);
    check("held_we", we_total - base, 1);
    check("held_wdata", we_wdata, 8'h81);

    // Reset in the middle of a dump frame.
    cpu_halted = 1'b0;
    core_mem[1] = 8'h5A;
    base = we_total;
    for (int k = 0; k < 5; k++) pulse(1'b1, 1'b0, 1);
    check("pre_rst_busy", o_busy, 1'b1);
    check("pre_rst_shift", o_shift_out, 1'b1);
    check("pre_rst_addr", reg_addr, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_shift", o_shift_out, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_err", o_err, 1'b0);
    check("mid_rst_we", reg_we, 1'b0);
    check("mid_rst_addr", reg_addr, 2'd0);
    core_mem[1] = 8'hC3;
    i_dump = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    b = 8'hC3;
    check("rel_rise_busy", o_busy, 1'b1);
    check("rel_rise_bit0", o_shift_out, b[7]);
    i_dump = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      pulse(1'b1, 1'b0, 1);
      check($sformatf("fresh_bit%0d", k), o_shift_out, b[7-k]);
    end
    check("fresh_busy_end", o_busy, 1'b0);
    check("rst_no_we", we_total - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spell_shift_port.md
SPELL_SHIFT_PORT -- requirements
Module: spell_shift_port

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2 (min 2), the number of input synchroniser flops per async pin.
REQ-002 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_load, i_dump, i_shift_in  in  1 each  async host pins: load strobe, dump strobe, serial data in.
REQ-005 SHALL have port i_reg_sel  in  2  async host register select (0 PC, 1 SP, 2 EXEC, 3 stack top).
REQ-006 SHALL have port cpu_halted  in  1  high when the CPU core is stopped or sleeping; register writes are legal only then.
REQ-007 SHALL have port reg_rdata  in  8  combinational read data of the core register addressed by reg_addr.
REQ-008 SHALL have ports reg_addr out 2, reg_wdata out 8, reg_we out 1  core register access port.
REQ-009 SHALL have ports o_shift_out out 1 (serial dump bit), o_busy out 1 (frame in progress), o_err out 1 (protocol error).

Function
REQ-010 SHALL pass i_load, i_dump, i_shift_in, i_reg_sel each through SYNC_STAGES flops; strobe rises detected as sync & ~prev.
REQ-011 Action for a strobe rise SHALL occur on clock edge SYNC_STAGES+1 counting the first edge that samples the pin high; a strobe held high SHALL count once.
REQ-012 SHALL keep 8-bit shift register shreg, 3-bit counter cnt, mode bit (0 load, 1 dump), latched select sel_q.
REQ-013 reg_addr SHALL equal synced i_reg_sel when cnt==0, else sel_q.
REQ-014 Rise with cnt==0 (frame start): SHALL latch sel_q, set mode, clear o_err.
REQ-015 Dump rise, cnt==0: shreg <= reg_rdata; cnt <= 1. Dump rise, cnt!=0, mode dump: shreg <= {shreg[6:0],0}; cnt <= cnt+1 (wraps 7->0).
REQ-016 o_shift_out SHALL equal shreg[7] at all times; host thus reads bits 7..0 after dump rises 1..8.
REQ-017 Load rise, same frame rules: shreg <= {shreg[6:0], synced i_shift_in}; cnt <= cnt+1 (wraps 7->0).
REQ-018 On the load rise that wraps cnt 7->0: if cpu_halted, reg_we SHALL pulse high exactly one cycle on the next edge with reg_wdata = final shreg, reg_addr = sel_q; else no write and o_err <= 1.
REQ-019 reg_wdata SHALL equal shreg continuously; reg_we high in no other case.
REQ-020 Rise of the opposite strobe type while cnt!=0: SHALL abort frame (cnt <= 0), o_err <= 1, no shift, no write.
REQ-021 Load and dump rises on the same cycle: SHALL be ignored except o_err <= 1 and cnt <= 0.
REQ-022 o_busy SHALL be high when cnt!=0 or reg_we is high.
REQ-023 o_err SHALL be sticky until rst or the next frame start.

Reset
REQ-024 rst SHALL asynchronously clear all synchroniser/prev flops, shreg, cnt, mode, sel_q, and force reg_we=0, o_shift_out=0, o_busy=0, o_err=0; reg_addr=0.
REQ-025 rst asserted mid-frame SHALL discard the frame with no write; first rise after release SHALL start a new frame.
REQ-026 A strobe already high at rst release SHALL be detected as a rise.

Verification
REQ-027 reg_sel=1, reg_rdata=8'hA5, 8 dump pulses -> o_shift_out after each = 1,0,1,0,0,1,0,1; o_busy low after 8th; no reg_we.
REQ-028 cpu_halted=1, reg_sel=2, load 8 bits 1,1,0,0,1,0,1,0 -> one reg_we pulse, reg_addr=2, reg_wdata=8'hCA, o_err=0.
REQ-029 Same load with cpu_halted=0 -> no reg_we, o_err=1; next frame start clears o_err.
REQ-030 3 load pulses then 1 dump pulse -> o_err=1, cnt=0, no write; following 8 loads write normally.
REQ-031 Load and dump pins raised simultaneously -> o_err=1, no shift, no write; single pulse held 20 cycles counts once.
REQ-032 rst pulsed after 5 dump pulses -> all outputs 0 within the same cycle; new 8-pulse dump returns fresh reg_rdata.
